// File: rtl/bd_pkg.sv
// Shared BuildingDrops definitions: keyboard scan codes, lane FSM states and
// default auto-repeat timing for a 50 MHz system clock.
package bd_pkg;

  localparam logic [7:0] KEY_LEFT_CODE  = 8'h6b;
  localparam logic [7:0] KEY_RIGHT_CODE = 8'h74;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_L = 2'd1,
    HOLD_R = 2'd2
  } state_t;

  // 0.5 s before the first repeat, then one repeat every 125 ms
  localparam int CLK_HZ               = 50_000_000;
  localparam int DEFAULT_REPEAT_DELAY = 25_000_000;
  localparam int DEFAULT_REPEAT_RATE  = 6_250_000;
  localparam int DEFAULT_CW           = 25;

endpackage

// File: rtl/lane_step.sv
// Combinational single-step lane arithmetic with wrap or saturate at the edges.
// Shared by the player mover and the enemy-lane logic.
module lane_step #(
  parameter int LANES = 4,
  parameter int LW    = 4,
  parameter int WRAP  = 1
) (
  input  logic [LW-1:0] lane,
  input  logic          inc,
  output logic [LW-1:0] next_lane,
  output logic          changed
);

  localparam logic [LW-1:0] TOP = LW'(LANES - 1);

  // Edges are detected explicitly so the result never depends on LW overflow
  always_comb begin
    next_lane = lane;
    changed   = 1'b0;
    if (inc) begin
      if (lane == TOP) begin
        if (WRAP != 0) begin
          next_lane = '0;
          changed   = 1'b1;
        end
      end else begin
        next_lane = lane + 1'b1;
        changed   = 1'b1;
      end
    end else begin
      if (lane == '0) begin
        if (WRAP != 0) begin
          next_lane = TOP;
          changed   = 1'b1;
        end
      end else begin
        next_lane = lane - 1'b1;
        changed   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_mover.sv
// Player-lane controller: press-to-move with hold-to-auto-repeat, wrap or
// saturate at the edges, and a registered move strobe for renderer and sound.
module lane_mover
  import bd_pkg::*;
#(
  parameter int          LANES        = 4,
  parameter int          LW           = 4,
  parameter int          START_LANE   = 0,
  parameter int          WRAP         = 1,
  parameter int          REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
  parameter int          REPEAT_RATE  = DEFAULT_REPEAT_RATE,
  parameter int          CW           = DEFAULT_CW,
  parameter logic [7:0]  KEY_LEFT     = KEY_LEFT_CODE,
  parameter logic [7:0]  KEY_RIGHT    = KEY_RIGHT_CODE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          scene_start,
  input  logic [7:0]    key,
  input  logic          key_valid,
  input  logic          key_released,
  output logic [LW-1:0] lane,
  output logic          moved,
  output logic          dir,
  output logic          at_edge
);

  localparam logic [CW-1:0] DELAY_LOAD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LOAD  = CW'(REPEAT_RATE - 1);

  state_t        state, next_state;
  logic [CW-1:0] cnt, cnt_next;
  logic          step_req, step_inc;
  logic [LW-1:0] step_lane;
  logic          step_changed;
  logic          move_pend, pend_dir;

  logic left_make, right_make, left_break, right_break;

  assign left_make   = key_valid && !key_released && (key == KEY_LEFT);
  assign right_make  = key_valid && !key_released && (key == KEY_RIGHT);
  assign left_break  = key_valid &&  key_released && (key == KEY_LEFT);
  assign right_break = key_valid &&  key_released && (key == KEY_RIGHT);

  lane_step #(
    .LANES (LANES),
    .LW    (LW),
    .WRAP  (WRAP)
  ) u_step (
    .lane      (lane),
    .inc       (step_inc),
    .next_lane (step_lane),
    .changed   (step_changed)
  );

  // Typematic makes of the held key fall through to the counter branch, so
  // the counter stays the only source of repeats.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    step_req   = 1'b0;
    step_inc   = 1'b0;
    if (scene_start || !enable) begin
      next_state = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (left_make) begin
            step_req   = 1'b1;
            step_inc   = 1'b1;
            next_state = HOLD_L;
            cnt_next   = DELAY_LOAD;
          end else if (right_make) begin
            step_req   = 1'b1;
            next_state = HOLD_R;
            cnt_next   = DELAY_LOAD;
          end
        end
        HOLD_L: begin
          if (right_make) begin
            step_req   = 1'b1;
            next_state = HOLD_R;
            cnt_next   = DELAY_LOAD;
          end else if (left_break) begin
            next_state = IDLE;
            cnt_next   = '0;
          end else if (cnt == '0) begin
            step_req = 1'b1;
            step_inc = 1'b1;
            cnt_next = RATE_LOAD;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
        HOLD_R: begin
          if (left_make) begin
            step_req   = 1'b1;
            step_inc   = 1'b1;
            next_state = HOLD_L;
            cnt_next   = DELAY_LOAD;
          end else if (right_break) begin
            next_state = IDLE;
            cnt_next   = '0;
          end else if (cnt == '0) begin
            step_req = 1'b1;
            cnt_next = RATE_LOAD;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
        default: begin
          next_state = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // moved/dir trail the lane change by one cycle through move_pend/pend_dir
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lane      <= LW'(START_LANE);
      move_pend <= 1'b0;
      pend_dir  <= 1'b0;
      moved     <= 1'b0;
      dir       <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_next;
      moved     <= move_pend;
      move_pend <= 1'b0;
      if (move_pend) begin
        dir <= pend_dir;
      end
      if (scene_start) begin
        lane <= LW'(START_LANE);
      end else if (step_req && step_changed) begin
        lane      <= step_lane;
        move_pend <= 1'b1;
        pend_dir  <= step_inc;
      end
    end
  end

  assign at_edge = (lane == '0) || (lane == LW'(LANES - 1));

endmodule

// File: doc/lane_mover.md
Name: lane_mover

Overview:
- Parametrised player-lane controller for the BuildingDrops game.
- Decodes left/right arrow key events from the PS/2 keyboard decoder and holds the player's lane index.
- Adds the following over the fixed 4-lane, move-on-release mover:
  - configurable lane count;
  - wrap or saturate at the edges;
  - press-to-move with hold-to-auto-repeat;
  - a one-cycle move strobe for the renderer and sound.

Parameters:
- LANES, 4, number of lanes; legal range 2..16.
- LW, 4, width of the lane output; must satisfy 2**LW >= LANES.
- START_LANE, 0, lane loaded on reset and on scene_start; must be < LANES.
- WRAP, 1, 1 = wrap around at the edges, 0 = saturate at the edges.
- REPEAT_DELAY, 25_000_000, number of clk cycles a key must be held before the first auto-repeat.
- REPEAT_RATE, 6_250_000, number of clk cycles between later auto-repeats.
- CW, 25, width of the repeat counter; must hold max(REPEAT_DELAY, REPEAT_RATE).
- KEY_LEFT, 8'h6b, scan code that increments the lane.
- KEY_RIGHT, 8'h74, scan code that decrements the lane.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  movement allowed (in-game scene AND expand); level signal.
- scene_start  in  1  one-cycle pulse on scene entry.
- key  in  8  scan code from the PS/2 decoder.
- key_valid  in  1  one-cycle strobe: key and key_released are valid this cycle.
- key_released  in  1  qualifies key_valid: 1 = break event, 0 = make event.
- lane  out  LW  current lane, range 0..LANES-1.
- moved  out  1  one-cycle pulse in the cycle after lane changes.
- dir  out  1  direction of the last move: 1 = left/increment, 0 = right/decrement.
- at_edge  out  1  combinational: lane==0 or lane==LANES-1.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - lane=START_LANE, moved=0, dir=0, state=IDLE, repeat counter=0.
- State machine (registered): IDLE, HOLD_L, HOLD_R.
  - IDLE + make event of KEY_LEFT with enable=1: step +1, go to HOLD_L, counter=REPEAT_DELAY-1.
  - IDLE + make event of KEY_RIGHT with enable=1: step -1, go to HOLD_R, counter=REPEAT_DELAY-1.
  - HOLD_x, counter != 0: decrement the counter.
  - HOLD_x, counter == 0: step in the held direction, reload counter=REPEAT_RATE-1.
  - HOLD_x + break event of the held key: go to IDLE with no step.
  - HOLD_x + make event of the opposite key: step in the new direction, switch to the other HOLD state, counter=REPEAT_DELAY-1 (last key wins).
  - Typematic repeat make events of the already-held key are ignored; the internal counter is the only source of repeats.
  - Any other scan code, or any break event in IDLE: no effect.
- Step arithmetic:
  - +1 at LANES-1: goes to 0 if WRAP=1; stays at LANES-1 if WRAP=0.
  - -1 at 0: goes to LANES-1 if WRAP=1; stays at 0 if WRAP=0.
  - A saturated step changes nothing: no lane change, no moved pulse, dir unchanged.
  - Use explicit comparisons; no reliance on modulo-2**LW overflow.
- Outputs:
  - Latency: lane updates on the clk edge that samples the triggering event or the counter expiry.
  - moved is high for exactly one cycle, one cycle after lane changes; moved and dir are registered.
- enable=0:
  - Forces state to IDLE and clears the counter.
  - Inhibits all steps.
  - lane holds its value.
- scene_start:
  - Has priority over all key and repeat activity in the same cycle.
  - lane=START_LANE, state=IDLE, no moved pulse.
- Simultaneous key_valid and counter expiry in the same cycle: the key event wins; at most one step per cycle.
- Reset asserted mid-hold: returns to reset values immediately; no pulse is emitted.

Decomposition:
- Package bd_pkg:
  - scan-code constants KEY_LEFT_CODE=8'h6b, KEY_RIGHT_CODE=8'h74;
  - state enum {IDLE, HOLD_L, HOLD_R};
  - the default timing constants for a 50 MHz clk.
- One sub-module, lane_step: combinational next-lane given lane, direction, LANES and WRAP. It returns the next lane and a changed flag, and is reused by the future enemy-lane logic.

Test Plan:
- Reset with LANES=4, START_LANE=0, WRAP=1, then one KEY_LEFT make event -> lane=1 on the next edge, moved pulse one cycle later, dir=1.
- WRAP=1, lane=0, KEY_RIGHT make then break -> lane=3, single moved pulse. With WRAP=0 the same stimulus -> lane stays 0, no moved pulse.
- Sim with REPEAT_DELAY=10, REPEAT_RATE=4, LANES=8; hold KEY_LEFT for 30 cycles, then break -> steps at cycles 0, 10, 14, 18, 22, 26; lane ends at 6; no step after the break.
- HOLD_L, then KEY_RIGHT make at cycle 5 -> immediate -1 step, state HOLD_R, repeat delay restarts.
- Key event coincident with scene_start -> lane=START_LANE, no moved pulse.
- enable dropped mid-hold -> no further steps and lane frozen. rst_n pulsed low for 1 ns between clk edges -> lane=START_LANE immediately.
